// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counting chain.
// Used by bcd_digit and by the bcd_count_ctrl top.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with clear, load (clamped to 9) and up/down advance.
// at_max_o/at_min_o feed the ripple-free enable chain in the top.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       adv_i,
  input  logic       dn_i,
  output logic [3:0] value_o,
  output logic       at_max_o,
  output logic       at_min_o
);

  logic [3:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 4'd0;
    end else if (ld_i) begin
      val_d = bcd_clamp(ld_val_i);
    end else if (adv_i) begin
      if (dn_i) val_d = (val_q == 4'd0) ? BCD_MAX : val_q - 4'd1;
      else      val_d = (val_q >= BCD_MAX) ? 4'd0 : val_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) val_q <= 4'd0;
    else          val_q <= val_d;
  end

  assign value_o  = val_q;
  assign at_max_o = (val_q == BCD_MAX);
  assign at_min_o = (val_q == 4'd0);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Single-clock prescaled N-digit BCD counter with start/stop/clear/load control.
// Define BCD_CTRL_DOWN_EN to honour dn_i (down counting); otherwise up-count only.
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int PRESC  = 10,
  parameter int WRAP   = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_bcd_i,
  input  logic                  dn_i,
  output logic [4*DIGITS-1:0]   q_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  carry_o,
  output logic                  run_o,
  output logic                  done_o
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [DIGITS-1:0]   digit_en_q, adv;
  logic                carry_q;
  logic [DIGITS-1:0]   at_max, at_min;
  logic [DIGITS:0]     lower_ok;
  logic                run_cnt, tick, terminal, halt, dn_eff, ld_eff;

`ifdef BCD_CTRL_DOWN_EN
  assign dn_eff = dn_i;
`else
  assign dn_eff = dn_i & 1'b0;
`endif

  // Counting happens only in RUN when no higher-priority command is present.
  assign run_cnt  = (state_q == RUN) && !clear_i && !load_i && !stop_i;
  assign tick     = run_cnt && (presc_q == PW'(PRESC - 1));
  assign terminal = lower_ok[DIGITS];
  assign halt     = tick && terminal && (WRAP == 0);
  assign ld_eff   = load_i && !clear_i;

  assign lower_ok[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign lower_ok[k+1] = lower_ok[k] && (dn_eff ? at_min[k] : at_max[k]);
    assign adv[k]        = tick && lower_ok[k] && !halt;

    bcd_digit u_digit (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (clear_i),
      .ld_i     (ld_eff),
      .ld_val_i (load_bcd_i[4*k +: 4]),
      .adv_i    (adv[k]),
      .dn_i     (dn_eff),
      .value_o  (q_o[4*k +: 4]),
      .at_max_o (at_max[k]),
      .at_min_o (at_min[k])
    );
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (clear_i) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (load_i) begin
      presc_d = '0;
      state_d = (state_q == IDLE) ? IDLE : HOLD;
    end else if (stop_i) begin
      // stop wins over a simultaneous start; DONE is left only by clear/load
      if (state_q == RUN || (start_i && state_q != DONE)) state_d = HOLD;
    end else begin
      if (start_i && state_q == IDLE) begin
        state_d = RUN;
        presc_d = '0;
      end else if (start_i && state_q == HOLD) begin
        state_d = RUN;
      end
      if (run_cnt) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (halt) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      digit_en_q <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digit_en_q <= adv;
      carry_q    <= tick && terminal;
    end
  end

  assign digit_en_o = digit_en_q;
  assign carry_o    = carry_q;
  assign run_o      = (state_q == RUN);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl: DIGITS=2, PRESC=4, one WRAP=1 and one WRAP=0 instance.
module tb_bcd_count_ctrl;

  logic       clk = 1'b0;
  logic       reset_i, start_i, stop_i, clear_i, load_i, dn_i;
  logic [7:0] load_bcd_i;

  logic [7:0] qw, qh;
  logic [1:0] enw, enh;
  logic       cw, ch, rw, rh, dw, dh;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_count_ctrl #(.DIGITS(2), .PRESC(4), .WRAP(1)) u_wrap (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .load_i(load_i), .load_bcd_i(load_bcd_i), .dn_i(dn_i),
    .q_o(qw), .digit_en_o(enw), .carry_o(cw), .run_o(rw), .done_o(dw)
  );

  bcd_count_ctrl #(.DIGITS(2), .PRESC(4), .WRAP(0)) u_halt (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .load_i(load_i), .load_bcd_i(load_bcd_i), .dn_i(dn_i),
    .q_o(qh), .digit_en_o(enh), .carry_o(ch), .run_o(rh), .done_o(dh)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1; step(1); clear_i = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_bcd_i = v; load_i = 1'b1; step(1); load_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1; step(1); start_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
    load_i = 1'b0; dn_i = 1'b0; load_bcd_i = 8'h00;
    step(2);
    chk("rst_q", qw, 8'h00);
    chk("rst_en", enw, 2'b00);
    chk("rst_carry", cw, 1'b0);
    chk("rst_run", rw, 1'b0);
    chk("rst_done", dh, 1'b0);
    reset_i = 1'b1;

    // 1: basic count, one update every 4 cycles after RUN entry
    do_start();
    chk("t1_run", rw, 1'b1);
    chk("t1_q0", qw, 8'h00);
    step(3);
    chk("t1_q_pre", qw, 8'h00);
    step(1);
    chk("t1_q1", qw, 8'h01);
    chk("t1_en1", enw, 2'b01);
    step(1);
    chk("t1_en_off", enw, 2'b00);
    step(3);
    chk("t1_q2", qw, 8'h02);
    pulse_clear();
    chk("t1_clr_q", qw, 8'h00);
    chk("t1_clr_run", rw, 1'b0);

    // 2: load 09 in IDLE, then carry into digit 1
    do_load(8'h09);
    chk("t2_ld_q", qw, 8'h09);
    chk("t2_ld_idle", rw, 1'b0);
    do_start();
    step(4);
    chk("t2_q", qw, 8'h10);
    chk("t2_en", enw, 2'b11);
    step(1);
    chk("t2_en_off", enw, 2'b00);
    chk("t2_q_hold", qw, 8'h10);
    pulse_clear();

    // 3: terminal count, wrap vs halt
    do_load(8'h99);
    do_start();
    step(4);
    chk("t3w_q", qw, 8'h00);
    chk("t3w_carry", cw, 1'b1);
    chk("t3w_en", enw, 2'b11);
    chk("t3w_run", rw, 1'b1);
    chk("t3h_q", qh, 8'h99);
    chk("t3h_carry", ch, 1'b1);
    chk("t3h_en", enh, 2'b00);
    chk("t3h_done", dh, 1'b1);
    chk("t3h_run", rh, 1'b0);
    step(1);
    chk("t3w_carry_off", cw, 1'b0);
    chk("t3h_carry_off", ch, 1'b0);
    chk("t3w_run_keep", rw, 1'b1);
    do_start();
    step(4);
    chk("t3h_start_ign", dh, 1'b1);
    chk("t3h_q_keep", qh, 8'h99);
    chk("t3h_carry_quiet", ch, 1'b0);
    pulse_clear();
    chk("t3h_clr_q", qh, 8'h00);
    chk("t3h_clr_done", dh, 1'b0);
    chk("t3h_clr_run", rh, 1'b0);

    // 4: stop mid-prescale at 05, hold, resume finishes remaining cycles
    do_load(8'h05);
    do_start();
    step(2);
    stop_i = 1'b1; step(1); stop_i = 1'b0;
    chk("t4_hold_run", rw, 1'b0);
    chk("t4_hold_q", qw, 8'h05);
    step(20);
    chk("t4_frozen", qw, 8'h05);
    chk("t4_frozen_en", enw, 2'b00);
    do_start();
    chk("t4_resume_run", rw, 1'b1);
    step(1);
    chk("t4_q_pre", qw, 8'h05);
    step(1);
    chk("t4_q6", qw, 8'h06);
    start_i = 1'b1; stop_i = 1'b1; step(1); start_i = 1'b0; stop_i = 1'b0;
    chk("t4_both_run", rw, 1'b0);
    step(8);
    chk("t4_both_q", qw, 8'h06);
    pulse_clear();

    // 5: reset mid-run right after an update
    do_load(8'h56);
    do_start();
    step(4);
    chk("t5_q57", qw, 8'h57);
    chk("t5_en", enw, 2'b01);
    reset_i = 1'b0; step(1);
    chk("t5_rst_q", qw, 8'h00);
    chk("t5_rst_en", enw, 2'b00);
    chk("t5_rst_run", rw, 1'b0);
    chk("t5_rst_carry", cw, 1'b0);
    reset_i = 1'b1;
    do_load(8'hAF);
    chk("t5_clamp", qw, 8'h99);
    do_load(8'hA3);
    chk("t5_clamp_hi", qw, 8'h93);

    // 6: direction input
    pulse_clear();
    dn_i = 1'b1;
    do_load(8'h10);
    do_start();
    step(4);
`ifdef BCD_CTRL_DOWN_EN
    chk("t6_dn_q", qw, 8'h09);
    chk("t6_dn_en", enw, 2'b11);
`else
    chk("t6_up_q", qw, 8'h11);
    chk("t6_up_en", enw, 2'b01);
`endif
    pulse_clear();
    do_load(8'h00);
    do_start();
    step(4);
`ifdef BCD_CTRL_DOWN_EN
    chk("t6w_under_q", qw, 8'h99);
    chk("t6w_under_carry", cw, 1'b1);
    chk("t6h_under_q", qh, 8'h00);
    chk("t6h_under_done", dh, 1'b1);
    chk("t6h_under_carry", ch, 1'b1);
`else
    chk("t6_up0_q", qw, 8'h01);
    chk("t6_up0_carry", cw, 1'b0);
    chk("t6_up0_halt_q", qh, 8'h01);
`endif
    dn_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
